atm_session_ctrl: RTL and testbench

Parametrised ATM session controller: the next generation of the team's ATM block. It authenticates a card holder (PIN plus face match, with a retry limit and lockout), then executes balance-inquiry, withdraw, deposit and optional mini-statement transactions against a single on-chip account register. It sits between the card/keypad front-end and the display/dispense logic, using valid/ready transaction handshakes and one-cycle completion pulses.

---
 rtl/atm_session_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM session controller. It authenticates the card holder
// with a PIN and a face match, and locks out after MAX_TRIES failures. It then
// runs inquiry, withdraw and deposit transactions against one on-chip balance.
// Optional feature macro: ATM_MINI_STMT_EN. When defined, a circular log of
// successful withdraws/deposits is kept and read out by type 2'b11.
// Handshake: a transaction is accepted on a clock edge where txn_ready and
// txn_valid are both high and card_in is high. txn_valid is not held or
// queued outside READY. txn_done is a one-cycle pulse. err_code, old_balance
// and new_balance are meaningful in the txn_done cycle.
module atm_session_ctrl #(
    parameter int BAL_W      = 16,
    parameter int PIN_W      = 16,
    parameter int PIN_VALUE  = 1234,
    parameter int MAX_TRIES  = 3,
    parameter int INIT_BAL   = 1000,
    parameter int STMT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin,
    input  logic             face_ok,
    input  logic             txn_valid,
    output logic             txn_ready,
    input  logic [1:0]       txn_type,
    input  logic [BAL_W-1:0] amount,
    output logic             pin_ok,
    output logic             locked,
    output logic             txn_done,
    output logic [1:0]       err_code,
    output logic [BAL_W-1:0] old_balance,
    output logic [BAL_W-1:0] new_balance,
    output logic             stmt_valid,
    output logic             stmt_type,
    output logic [BAL_W-1:0] stmt_amount
);
    localparam logic [PIN_W-1:0] PIN_C     = PIN_W'(PIN_VALUE);
    localparam logic [BAL_W-1:0] BAL_INIT  = BAL_W'(INIT_BAL);
    localparam logic [3:0]       TRIES_MAX = 4'(MAX_TRIES);

    // Reject illegal configurations at elaboration time
    if (MAX_TRIES < 1 || MAX_TRIES > 15 || STMT_DEPTH < 2 ||
        (STMT_DEPTH & (STMT_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("atm_session_ctrl: illegal MAX_TRIES or STMT_DEPTH");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AUTH   = 3'd1,
        S_READY  = 3'd2,
        S_EXEC   = 3'd3,
        S_STMT   = 3'd4,
        S_LOCKED = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       tries_q, tries_d;
    logic [1:0]       type_q, type_d;
    logic [BAL_W-1:0] amt_q, amt_d, bal_q, bal_d, old_q, old_d;
    logic [1:0]       err_q, err_d;
    logic             done_q, done_d;

    logic             auth_pass, tries_full, accept, stmt_last;
    logic             withdraw_ok, deposit_ok;
    logic [BAL_W:0]   sum_w;

    assign auth_pass   = (pin == PIN_C) && face_ok;
    assign tries_full  = (tries_q + 4'd1) >= TRIES_MAX;
    assign accept      = card_in && txn_valid;
    // One extra bit so an overflowing deposit is detected instead of wrapping
    assign sum_w       = {1'b0, bal_q} + {1'b0, amt_q};
    assign withdraw_ok = (type_q == 2'b01) && (amt_q <= bal_q);
    assign deposit_ok  = (type_q == 2'b10) && !sum_w[BAL_W];

`ifdef ATM_MINI_STMT_EN
    localparam bit STMT_EN = 1'b1;
    localparam int PTR_W   = $clog2(STMT_DEPTH);

    logic             log_type_q [STMT_DEPTH];
    logic             log_type_d [STMT_DEPTH];
    logic [BAL_W-1:0] log_amt_q  [STMT_DEPTH];
    logic [BAL_W-1:0] log_amt_d  [STMT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d, left_q, left_d;
    logic             stmt_valid_q, stmt_valid_d, stmt_type_q, stmt_type_d;
    logic [BAL_W-1:0] stmt_amount_q, stmt_amount_d;

    assign stmt_last = (left_q <= (PTR_W+1)'(1));
`else
    localparam bit STMT_EN = 1'b0;
    assign stmt_last = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; card removal takes priority over a same-cycle request
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (card_in) state_d = S_AUTH;
            S_AUTH: begin
                if (!card_in)           state_d = S_IDLE;
                else if (pin_valid) begin
                    if (auth_pass)       state_d = S_READY;
                    else if (tries_full) state_d = S_LOCKED;
                end
            end
            S_READY: begin
                if (!card_in)           state_d = S_IDLE;
                else if (txn_valid)     state_d = (txn_type == 2'b11 && STMT_EN) ? S_STMT : S_EXEC;
            end
            S_EXEC:   state_d = card_in ? S_READY : S_IDLE;
            S_STMT:   if (stmt_last) state_d = card_in ? S_READY : S_IDLE;
            S_LOCKED: state_d = S_LOCKED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state
    always_comb begin
        txn_ready = 1'b0;
        pin_ok    = 1'b0;
        locked    = 1'b0;
        case (state_q)
            S_READY:         begin txn_ready = 1'b1; pin_ok = 1'b1; end
            S_EXEC, S_STMT:  pin_ok = 1'b1;
            S_LOCKED:        locked = 1'b1;
            default:         ;
        endcase
    end

    // Datapath: try counter, request capture, balance update and completion
    always_comb begin
        tries_d = tries_q;
        type_d  = type_q;
        amt_d   = amt_q;
        bal_d   = bal_q;
        old_d   = old_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_AUTH: if (card_in && pin_valid) tries_d = auth_pass ? 4'd0 : tries_q + 4'd1;
            S_READY: if (accept) begin
                type_d = txn_type;
                amt_d  = amount;
            end
            S_EXEC: begin
                done_d = 1'b1;
                old_d  = bal_q;
                err_d  = 2'd0;
                case (type_q)
                    2'b01: if (withdraw_ok) bal_d = bal_q - amt_q; else err_d = 2'd1;
                    2'b10: if (deposit_ok) bal_d = sum_w[BAL_W-1:0]; else err_d = 2'd2;
                    2'b11: err_d = 2'd3;
                    default: ;
                endcase
            end
            S_STMT: if (stmt_last) begin
                done_d = 1'b1;
                old_d  = bal_q;
                err_d  = 2'd0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tries_q <= 4'd0;
            type_q  <= 2'b00;
            amt_q   <= '0;
            bal_q   <= BAL_INIT;
            old_q   <= BAL_INIT;
            err_q   <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            tries_q <= tries_d;
            type_q  <= type_d;
            amt_q   <= amt_d;
            bal_q   <= bal_d;
            old_q   <= old_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef ATM_MINI_STMT_EN
    // Log write on successful withdraw/deposit; readout newest-first in STMT
    always_comb begin
        log_type_d    = log_type_q;
        log_amt_d     = log_amt_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        left_d        = left_q;
        stmt_valid_d  = 1'b0;
        stmt_type_d   = 1'b0;
        stmt_amount_d = '0;
        if (state_q == S_EXEC && (withdraw_ok || deposit_ok)) begin
            log_type_d[wr_ptr_q] = type_q[1];
            log_amt_d[wr_ptr_q]  = amt_q;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            if (count_q != (PTR_W+1)'(STMT_DEPTH)) count_d = count_q + (PTR_W+1)'(1);
        end
        if (state_q == S_READY && accept && txn_type == 2'b11) begin
            rd_ptr_d = wr_ptr_q - PTR_W'(1);
            left_d   = count_q;
        end
        if (state_q == S_STMT && left_q != '0) begin
            stmt_valid_d  = 1'b1;
            stmt_type_d   = log_type_q[rd_ptr_q];
            stmt_amount_d = log_amt_q[rd_ptr_q];
            rd_ptr_d      = rd_ptr_q - PTR_W'(1);
            left_d        = left_q - (PTR_W+1)'(1);
        end
    end

    // Log and statement output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STMT_DEPTH; i++) begin
                log_type_q[i] <= 1'b0;
                log_amt_q[i]  <= '0;
            end
            wr_ptr_q      <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            left_q        <= '0;
            stmt_valid_q  <= 1'b0;
            stmt_type_q   <= 1'b0;
            stmt_amount_q <= '0;
        end else begin
            log_type_q    <= log_type_d;
            log_amt_q     <= log_amt_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            left_q        <= left_d;
            stmt_valid_q  <= stmt_valid_d;
            stmt_type_q   <= stmt_type_d;
            stmt_amount_q <= stmt_amount_d;
        end
    end

    assign stmt_valid  = stmt_valid_q;
    assign stmt_type   = stmt_type_q;
    assign stmt_amount = stmt_amount_q;
`else
    assign stmt_valid  = 1'b0;
    assign stmt_type   = 1'b0;
    assign stmt_amount = '0;
`endif

    assign txn_done    = done_q;
    assign err_code    = err_q;
    assign old_balance = old_q;
    assign new_balance = bal_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Testbench for atm_session_ctrl. It applies a table of per-cycle vectors and
// then runs hand-written sequences for lockout, reset during EXEC and the
// mini statement.
module tb_atm_session_ctrl;
    logic        clk = 1'b0;
    logic        rst, card_in, pin_valid, face_ok, txn_valid;
    logic [15:0] pin, amount;
    logic [1:0]  txn_type;
    logic        txn_ready, pin_ok, locked, txn_done, stmt_valid, stmt_type;
    logic [1:0]  err_code;
    logic [15:0] old_balance, new_balance, stmt_amount;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic        card, pv;
        logic [15:0] pin;
        logic        face, tv;
        logic [1:0]  tt;
        logic [15:0] amt;
        logic        e_pin_ok, e_locked, e_ready, e_done;
        logic [1:0]  e_err;
        logic [15:0] e_old, e_new;
    } vec_t;

    vec_t vecs[26];

    atm_session_ctrl #(
        .BAL_W(16), .PIN_W(16), .PIN_VALUE(1234), .MAX_TRIES(3),
        .INIT_BAL(1000), .STMT_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .card_in(card_in), .pin_valid(pin_valid),
        .pin(pin), .face_ok(face_ok), .txn_valid(txn_valid),
        .txn_ready(txn_ready), .txn_type(txn_type), .amount(amount),
        .pin_ok(pin_ok), .locked(locked), .txn_done(txn_done),
        .err_code(err_code), .old_balance(old_balance),
        .new_balance(new_balance), .stmt_valid(stmt_valid),
        .stmt_type(stmt_type), .stmt_amount(stmt_amount)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic c, pv, input logic [15:0] p,
                                input logic f, tv, input logic [1:0] tt,
                                input logic [15:0] a, input logic po, lk, rd, dn,
                                input logic [1:0] er, input logic [15:0] ob, nb);
        vec_t v;
        v.card = c; v.pv = pv; v.pin = p; v.face = f; v.tv = tv; v.tt = tt; v.amt = a;
        v.e_pin_ok = po; v.e_locked = lk; v.e_ready = rd; v.e_done = dn;
        v.e_err = er; v.e_old = ob; v.e_new = nb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, pv, input logic [15:0] p, input logic f, tv,
                         input logic [1:0] tt, input logic [15:0] a);
        card_in = c; pin_valid = pv; pin = p; face_ok = f;
        txn_valid = tv; txn_type = tt; amount = a;
    endtask

    // Advance one active edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic login();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 16'd1234, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // card pv pin face tv tt amt | pin_ok locked ready done err old new
        vecs[0]  = mk(1,0,0,0,0,0,0,         0,0,0,0,0,1000,1000);
        vecs[1]  = mk(1,1,1234,1,0,0,0,      1,0,1,0,0,1000,1000);
        vecs[2]  = mk(1,0,0,0,1,1,300,       1,0,0,0,0,1000,1000);
        vecs[3]  = mk(1,0,0,0,0,0,0,         1,0,1,1,0,1000,700);
        vecs[4]  = mk(1,0,0,0,0,0,0,         1,0,1,0,0,1000,700);
        vecs[5]  = mk(1,0,0,0,1,1,701,       1,0,0,0,0,1000,700);
        vecs[6]  = mk(1,0,0,0,0,0,0,         1,0,1,1,1,700,700);
        vecs[7]  = mk(1,0,0,0,1,2,65000,     1,0,0,0,0,700,700);
        vecs[8]  = mk(1,0,0,0,0,0,0,         1,0,1,1,2,700,700);
        vecs[9]  = mk(1,0,0,0,1,2,300,       1,0,0,0,0,700,700);
        vecs[10] = mk(1,0,0,0,0,0,0,         1,0,1,1,0,700,1000);
        vecs[11] = mk(1,0,0,0,1,0,55,        1,0,0,0,0,700,1000);
        vecs[12] = mk(1,0,0,0,0,0,0,         1,0,1,1,0,1000,1000);
        vecs[13] = mk(0,0,0,0,1,1,10,        0,0,0,0,0,1000,1000);
        vecs[14] = mk(0,0,0,0,1,2,5,         0,0,0,0,0,1000,1000);
        vecs[15] = mk(1,0,0,0,0,0,0,         0,0,0,0,0,1000,1000);
        vecs[16] = mk(1,1,1234,0,0,0,0,      0,0,0,0,0,1000,1000);
        vecs[17] = mk(1,1,1234,1,0,0,0,      1,0,1,0,0,1000,1000);
        vecs[18] = mk(1,0,0,0,1,1,0,         1,0,0,0,0,1000,1000);
        vecs[19] = mk(1,0,0,0,1,1,5,         1,0,1,1,0,1000,1000);
        vecs[20] = mk(1,0,0,0,1,1,1000,      1,0,0,0,0,1000,1000);
        vecs[21] = mk(1,0,0,0,0,0,0,         1,0,1,1,0,1000,0);
        vecs[22] = mk(1,0,0,0,1,2,65535,     1,0,0,0,0,1000,0);
        vecs[23] = mk(1,0,0,0,0,0,0,         1,0,1,1,0,0,65535);
        vecs[24] = mk(1,0,0,0,1,2,1,         1,0,0,0,0,0,65535);
        vecs[25] = mk(1,0,0,0,0,0,0,         1,0,1,1,2,65535,65535);

        // Reset values
        do_reset();
        chk("rst txn_ready", 32'(txn_ready), 0);
        chk("rst pin_ok", 32'(pin_ok), 0);
        chk("rst locked", 32'(locked), 0);
        chk("rst txn_done", 32'(txn_done), 0);
        chk("rst err_code", 32'(err_code), 0);
        chk("rst old_balance", 32'(old_balance), 1000);
        chk("rst new_balance", 32'(new_balance), 1000);
        chk("rst stmt_valid", 32'(stmt_valid), 0);
        chk("rst stmt_type", 32'(stmt_type), 0);
        chk("rst stmt_amount", 32'(stmt_amount), 0);
        chk("rst state", 32'(dut.state_q), 0);

        // Table-driven vectors, one clock edge per entry
        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].card, vecs[i].pv, vecs[i].pin, vecs[i].face,
                  vecs[i].tv, vecs[i].tt, vecs[i].amt);
            tick();
            chk($sformatf("v%0d pin_ok", i), 32'(pin_ok), 32'(vecs[i].e_pin_ok));
            chk($sformatf("v%0d locked", i), 32'(locked), 32'(vecs[i].e_locked));
            chk($sformatf("v%0d txn_ready", i), 32'(txn_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d txn_done", i), 32'(txn_done), 32'(vecs[i].e_done));
            if (vecs[i].e_done)
                chk($sformatf("v%0d err_code", i), 32'(err_code), 32'(vecs[i].e_err));
            chk($sformatf("v%0d old_balance", i), 32'(old_balance), 32'(vecs[i].e_old));
            chk($sformatf("v%0d new_balance", i), 32'(new_balance), 32'(vecs[i].e_new));
            chk($sformatf("v%0d stmt_valid", i), 32'(stmt_valid), 0);
        end

        // Lockout: failures persist across card removal
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 16'd1111, 1, 0, 0, 0); tick();
        chk("lock after 1 fail", 32'(locked), 0);
        drive(1, 1, 16'd1111, 1, 0, 0, 0); tick();
        chk("lock after 2 fails", 32'(locked), 0);
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 16'd1111, 1, 0, 0, 0); tick();
        chk("lock after 3 fails", 32'(locked), 1);
        chk("lock pin_ok", 32'(pin_ok), 0);
        drive(1, 1, 16'd1234, 1, 0, 0, 0); tick();
        chk("lock good pin locked", 32'(locked), 1);
        chk("lock good pin pin_ok", 32'(pin_ok), 0);
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 16'd1234, 1, 1, 1, 5); tick();
        chk("lock reinsert locked", 32'(locked), 1);
        chk("lock reinsert ready", 32'(txn_ready), 0);
        do_reset();
        chk("lock cleared by rst", 32'(locked), 0);

        // Reset during the EXEC cycle cancels the transaction
        login();
        drive(1, 0, 0, 0, 1, 1, 300); tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("exec rst txn_done", 32'(txn_done), 0);
        chk("exec rst new_balance", 32'(new_balance), 1000);
        chk("exec rst pin_ok", 32'(pin_ok), 0);
        chk("exec rst state", 32'(dut.state_q), 0);

        // Mini statement
        do_reset();
        login();
`ifdef ATM_MINI_STMT_EN
        drive(1, 0, 0, 0, 1, 3, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        chk("stmt empty txn_done", 32'(txn_done), 1);
        chk("stmt empty stmt_valid", 32'(stmt_valid), 0);
        for (int d = 1; d <= 5; d++) begin
            drive(1, 0, 0, 0, 1, 2, 16'(d)); tick();
            drive(1, 0, 0, 0, 0, 0, 0); tick();
            chk($sformatf("stmt dep%0d err", d), 32'(err_code), 0);
        end
        chk("stmt balance", 32'(new_balance), 1015);
        drive(1, 0, 0, 0, 1, 3, 0); tick();
        for (int a = 5; a >= 2; a--) exp_q.push_back(16'(a));
        for (int k = 0; k < 4; k++) begin
            logic [15:0] e;
            drive(1, 0, 0, 0, 0, 0, 0); tick();
            e = exp_q.pop_front();
            chk($sformatf("stmt%0d valid", k), 32'(stmt_valid), 1);
            chk($sformatf("stmt%0d amount", k), 32'(stmt_amount), 32'(e));
            chk($sformatf("stmt%0d type", k), 32'(stmt_type), 1);
            chk($sformatf("stmt%0d txn_done", k), 32'(txn_done), (k == 3) ? 1 : 0);
        end
        tick();
        chk("stmt end valid", 32'(stmt_valid), 0);
        chk("stmt end txn_done", 32'(txn_done), 0);
`else
        drive(1, 0, 0, 0, 1, 3, 7); tick();
        chk("stmt accept ready", 32'(txn_ready), 0);
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        chk("stmt txn_done", 32'(txn_done), 1);
        chk("stmt err_code", 32'(err_code), 3);
        chk("stmt new_balance", 32'(new_balance), 1000);
        chk("stmt old_balance", 32'(old_balance), 1000);
        chk("stmt stmt_valid", 32'(stmt_valid), 0);
        tick();
        chk("stmt done low", 32'(txn_done), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
